// File: rtl/texture_pkg.sv
// Shared types and helpers for the texture sampler: sprite config record,
// shade encoding and the palette lookup (index -> 12-bit RGB).
package texture_pkg;

  localparam int TEX_ID_W_MAX = 8;

  localparam logic [1:0] SHADE_FULL = 2'd0;
  localparam logic [1:0] SHADE_3Q   = 2'd1;
  localparam logic [1:0] SHADE_HALF = 2'd2;
  localparam logic [1:0] SHADE_1Q   = 2'd3;

  typedef struct packed {
    logic [9:0]              x0;
    logic [9:0]              y0;
    logic [1:0]              scale;
    logic [TEX_ID_W_MAX-1:0] tex_id;
    logic [1:0]              shade;
    logic                    enable;
  } sprite_cfg_t;

  function automatic logic [2:0] shade_mult(input logic [1:0] shade);
    logic [2:0] m;
    case (shade)
      SHADE_FULL: m = 3'd4;
      SHADE_3Q:   m = 3'd3;
      SHADE_HALF: m = 3'd2;
      default:    m = 3'd1;
    endcase
    return m;
  endfunction

  // Scale one 4-bit channel by (4 - shade)/4, truncating.
  function automatic logic [3:0] apply_shade(input logic [3:0] c, input logic [1:0] shade);
    logic [6:0] p;
    p = {3'b000, c} * {4'b0000, shade_mult(shade)};
    return 4'(p >> 2);
  endfunction

  function automatic logic [11:0] palette(input logic [7:0] idx);
    logic [11:0] rgb;
    if (idx == 8'd1) rgb = 12'hF84;
    else             rgb = {idx[3:0], idx[7:4], idx[3:0] ^ idx[7:4]};
    return rgb;
  endfunction

endpackage

// File: rtl/texture_sampler_rom.sv
// Synchronous-read texel ROM holding NUM_TEX textures of palette indices,
// contents taken from the built-in texel image below.
module texture_sampler_rom #(
  parameter int NUM_TEX    = 4,
  parameter int TEX_W_LOG2 = 4,
  parameter int TEX_H_LOG2 = 4,
  parameter int IDX_W      = 8,
  localparam int ADDR_W    = $clog2(NUM_TEX * (1 << (TEX_W_LOG2 + TEX_H_LOG2)))
) (
  input  logic              vga_clk,
  input  logic [ADDR_W-1:0] addr,
  output logic [IDX_W-1:0]  data
);

  // Every 16th texel is transparent (low nibble 15) and every row-start texel uses index 1.
  function automatic logic [IDX_W-1:0] texel_image(input int unsigned a);
    logic [IDX_W-1:0] t;
    if (a % 16 == 15)     t = '0;
    else if (a % 16 == 0) t = IDX_W'(1);
    else                  t = IDX_W'((a * 7 + 3) % 256);
    return t;
  endfunction

  always_ff @(posedge vga_clk) begin
    data <= texel_image(32'(addr));
  end

endmodule

// File: rtl/texture_sampler.sv
// Sprite texture sampler: double-buffered sprite config, 3-stage pixel
// pipeline (rect test + address, ROM read, palette + shade).
module texture_sampler
  import texture_pkg::*;
#(
  parameter int TEX_W_LOG2 = 4,
  parameter int TEX_H_LOG2 = 4,
  parameter int NUM_TEX    = 4,
  parameter int IDX_W      = 8,
  localparam int TID_W     = (NUM_TEX > 1) ? $clog2(NUM_TEX) : 1,
  localparam int ADDR_W    = $clog2(NUM_TEX * (1 << (TEX_W_LOG2 + TEX_H_LOG2)))
) (
  input  logic             vga_clk,
  input  logic             reset,
  input  logic [9:0]       DrawX,
  input  logic [9:0]       DrawY,
  input  logic             blank,
  input  logic             frame_start,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [9:0]       cfg_x0,
  input  logic [9:0]       cfg_y0,
  input  logic [1:0]       cfg_scale,
  input  logic [TID_W-1:0] cfg_tex_id,
  input  logic [1:0]       cfg_shade,
  input  logic             cfg_enable,
  output logic [3:0]       red,
  output logic [3:0]       green,
  output logic [3:0]       blue,
  output logic             hit
);

  localparam int TEX_W = 1 << TEX_W_LOG2;
  localparam int TEX_H = 1 << TEX_H_LOG2;

  sprite_cfg_t cfg_in, shadow, active;
  logic        pending_full;

  assign cfg_ready = !pending_full;
  assign cfg_in = '{x0: cfg_x0, y0: cfg_y0, scale: cfg_scale,
                    tex_id: TEX_ID_W_MAX'(cfg_tex_id), shade: cfg_shade,
                    enable: cfg_enable};

  // Commit only happens with a pending set, so it never collides with a transfer.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      pending_full <= 1'b0;
      active       <= '0;
    end else if (frame_start && pending_full) begin
      active       <= shadow;
      pending_full <= 1'b0;
    end else if (cfg_valid && cfg_ready) begin
      pending_full <= 1'b1;
    end
  end

  always_ff @(posedge vga_clk) begin
    if (cfg_valid && cfg_ready) shadow <= cfg_in;
  end

  logic [10:0]           dx, dy, lim_x, lim_y;
  logic [TEX_W_LOG2-1:0] u;
  logic [TEX_H_LOG2-1:0] v;
  logic                  in_rect;
  logic [ADDR_W-1:0]     rom_addr_d, rom_addr;

  // 11-bit differences: bit 10 set means the pixel is left of / above the sprite.
  assign dx      = {1'b0, DrawX} - {1'b0, active.x0};
  assign dy      = {1'b0, DrawY} - {1'b0, active.y0};
  assign lim_x   = 11'(TEX_W) << active.scale;
  assign lim_y   = 11'(TEX_H) << active.scale;
  assign in_rect = !dx[10] && !dy[10] && (dx < lim_x) && (dy < lim_y);
  assign u       = TEX_W_LOG2'(dx >> active.scale);
  assign v       = TEX_H_LOG2'(dy >> active.scale);
  assign rom_addr_d = ADDR_W'(int'(active.tex_id) * TEX_W * TEX_H + int'(v) * TEX_W + int'(u));

  logic             qual_s1, qual_s2;
  logic [1:0]       shade_s1, shade_s2;
  logic [IDX_W-1:0] rom_idx;
  logic [11:0]      pal_rgb;

  always_ff @(posedge vga_clk) begin
    rom_addr <= rom_addr_d;
    shade_s1 <= active.shade;
    shade_s2 <= shade_s1;
  end

  texture_sampler_rom #(
    .NUM_TEX    (NUM_TEX),
    .TEX_W_LOG2 (TEX_W_LOG2),
    .TEX_H_LOG2 (TEX_H_LOG2),
    .IDX_W      (IDX_W)
  ) u_rom (
    .vga_clk (vga_clk),
    .addr    (rom_addr),
    .data    (rom_idx)
  );

  assign pal_rgb = palette(8'(rom_idx));

  always_ff @(posedge vga_clk) begin
    if (reset) begin
      qual_s1 <= 1'b0;
      qual_s2 <= 1'b0;
      hit     <= 1'b0;
      red     <= 4'd0;
      green   <= 4'd0;
      blue    <= 4'd0;
    end else begin
      qual_s1 <= in_rect && active.enable && blank;
      qual_s2 <= qual_s1;
      if (qual_s2 && rom_idx != '0) begin
        hit   <= 1'b1;
        red   <= apply_shade(pal_rgb[11:8], shade_s2);
        green <= apply_shade(pal_rgb[7:4],  shade_s2);
        blue  <= apply_shade(pal_rgb[3:0],  shade_s2);
      end else begin
        hit   <= 1'b0;
        red   <= 4'd0;
        green <= 4'd0;
        blue  <= 4'd0;
      end
    end
  end

endmodule

// File: tb/tb_texture_sampler.sv
// Self-checking bench for texture_sampler: directed scenarios plus randomized
// pixel streams compared against a transaction-level sprite model.
module tb_texture_sampler;

  logic       vga_clk = 1'b0;
  logic       reset, blank, frame_start, cfg_valid, cfg_ready, cfg_enable, hit;
  logic [9:0] DrawX, DrawY, cfg_x0, cfg_y0;
  logic [1:0] cfg_scale, cfg_tex_id, cfg_shade;
  logic [3:0] red, green, blue;

  always #5 vga_clk = ~vga_clk;

  texture_sampler dut (
    .vga_clk(vga_clk), .reset(reset), .DrawX(DrawX), .DrawY(DrawY), .blank(blank),
    .frame_start(frame_start), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_x0(cfg_x0), .cfg_y0(cfg_y0), .cfg_scale(cfg_scale), .cfg_tex_id(cfg_tex_id),
    .cfg_shade(cfg_shade), .cfg_enable(cfg_enable),
    .red(red), .green(green), .blue(blue), .hit(hit)
  );

  typedef struct { int due; logic [12:0] v; } exp_t;
  exp_t q[$];
  int   cyc, n_pass, n_tot;
  // model: bus, shadow and active sprite settings
  int   bx0, by0, bsc, btid, bsh; bit ben;
  int   sx0, sy0, ssc, stid, ssh; bit sen;
  int   ax0, ay0, asc, atid, ash; bit aen;
  bit   m_pend;

  function automatic int texel(input int a);
    if (a % 16 == 15) return 0;
    if (a % 16 == 0)  return 1;
    return (a * 7 + 3) % 256;
  endfunction

  function automatic logic [12:0] model(input int x, input int y, input bit b);
    int dx, dy, w, addr, idx, r, g, bl, k;
    if (!b || !aen) return 13'd0;
    dx = x - ax0; dy = y - ay0; w = 16 * (1 << asc);
    if (dx < 0 || dy < 0 || dx >= w || dy >= w) return 13'd0;
    addr = atid * 256 + (dy / (1 << asc)) * 16 + dx / (1 << asc);
    idx  = texel(addr);
    if (idx == 0) return 13'd0;
    if (idx == 1) begin r = 15; g = 8; bl = 4; end
    else begin r = idx % 16; g = idx / 16; bl = r ^ g; end
    k = 4 - ash;
    return {1'b1, 4'(r * k / 4), 4'(g * k / 4), 4'(bl * k / 4)};
  endfunction

  task automatic tick();
    @(posedge vga_clk); #1; cyc++;
  endtask

  task automatic set_bus(input int x0, input int y0, input int sc, input int tid, input int sh, input bit en);
    cfg_x0 = 10'(x0); cfg_y0 = 10'(y0); cfg_scale = 2'(sc);
    cfg_tex_id = 2'(tid); cfg_shade = 2'(sh); cfg_enable = en;
    bx0 = x0; by0 = y0; bsc = sc; btid = tid; bsh = sh; ben = en;
  endtask

  task automatic model_accept();
    sx0 = bx0; sy0 = by0; ssc = bsc; stid = btid; ssh = bsh; sen = ben; m_pend = 1;
  endtask

  task automatic model_commit();
    if (m_pend) begin
      ax0 = sx0; ay0 = sy0; asc = ssc; atid = stid; ash = ssh; aen = sen; m_pend = 0;
    end
  endtask

  task automatic model_reset();
    ax0 = 0; ay0 = 0; asc = 0; atid = 0; ash = 0; aen = 0; m_pend = 0; q.delete();
  endtask

  task automatic send_cfg(input int x0, input int y0, input int sc, input int tid, input int sh, input bit en);
    bit ok = 0;
    blank = 0; set_bus(x0, y0, sc, tid, sh, en); cfg_valid = 1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (cfg_ready) ok = 1;
      tick();
    end
    cfg_valid = 0;
    n_tot++;
    if (!ok) $display("FAIL cfg_handshake: got cfg_ready=0 for 20 cycles expected 1");
    else begin n_pass++; model_accept(); end
  endtask

  task automatic commit();
    blank = 0; frame_start = 1; model_commit(); tick(); frame_start = 0;
  endtask

  // One pixel per cycle; reports the check falling due this cycle to the caller.
  task automatic step(input int x, input int y, input bit b, input bit fs, input int force_exp,
                      output bit due, output logic [12:0] expv, output logic [12:0] obs);
    due = 0; expv = '0; obs = {hit, red, green, blue};
    if (q.size() > 0 && q[0].due == cyc) begin due = 1; expv = q[0].v; void'(q.pop_front()); end
    DrawX = 10'(x); DrawY = 10'(y); blank = b; frame_start = fs;
    q.push_back('{cyc + 3, (force_exp >= 0) ? 13'(force_exp) : model(x, y, b)});
    if (fs) model_commit();
    tick();
    frame_start = 0;
  endtask

  task automatic drain(input string name);
    logic [12:0] o;
    for (int i = 0; i < 8 && q.size() > 0; i++) begin
      if (q[0].due == cyc) begin
        o = {hit, red, green, blue}; n_tot++;
        if (o !== q[0].v) $display("FAIL %s drain: got %h expected %h", name, o, q[0].v);
        else n_pass++;
        void'(q.pop_front());
      end
      blank = 0; tick();
    end
    if (q.size() > 0) begin
      n_tot++; $display("FAIL %s drain_timeout: got %0d pending expected 0", name, q.size()); q.delete();
    end
  endtask

  task automatic stream_region(input string name, input int n, input int bx, input int by,
                               input int sc, input int fs_at);
    bit due; logic [12:0] e, o; int span, x, y;
    span = (16 << sc) + 8;
    for (int i = 0; i < n; i++) begin
      x = bx + int'($urandom_range(span)) - 4; if (x < 0) x = 0; if (x > 639) x = 639;
      y = by + int'($urandom_range(span)) - 4; if (y < 0) y = 0; if (y > 479) y = 479;
      step(x, y, ($urandom_range(9) != 0), (i == fs_at), -1, due, e, o);
      if (due) begin
        n_tot++;
        if (o !== e) $display("FAIL %s px%0d (%0d,%0d): got %h expected %h", name, i, x, y, o, e);
        else n_pass++;
      end
    end
    drain(name);
  endtask

  task automatic run_fixed(input string name, input int x, input int y, input bit b, input int fe);
    bit due; logic [12:0] e, o;
    step(x, y, b, 0, fe, due, e, o);
    if (due) begin
      n_tot++;
      if (o !== e) $display("FAIL %s: got %h expected %h", name, o, e); else n_pass++;
    end
  endtask

  task automatic test_reset();
    reset = 1; repeat (3) tick();
    n_tot++; if ({hit, red, green, blue} !== 13'd0) $display("FAIL reset_out: got %h expected 0", {hit, red, green, blue}); else n_pass++;
    n_tot++; if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected 1", cfg_ready); else n_pass++;
    reset = 0; model_reset();
    stream_region("reset_disabled", 20, 0, 0, 2, -1);
  endtask

  task automatic test_basic();
    send_cfg(100, 50, 0, 1, 0, 1); commit();
    DrawX = 100; DrawY = 50; blank = 1; tick(); blank = 0; tick();
    n_tot++; if ({hit, red, green, blue} !== 13'd0) $display("FAIL basic_early: got %h expected 0", {hit, red, green, blue}); else n_pass++;
    tick();
    n_tot++; if ({hit, red, green, blue} !== 13'h1F84) $display("FAIL basic_first: got %h expected 1f84", {hit, red, green, blue}); else n_pass++;
    stream_region("basic_stream", 40, 100, 50, 0, -1);
  endtask

  task automatic test_scale();
    send_cfg(0, 0, 2, 0, 0, 1); commit();
    for (int x = 0; x < 4; x++) run_fixed("scale_block", x, 0, 1, 13'h1F84);
    run_fixed("scale_next_texel", 4, 0, 1, 13'h1A0A);
    run_fixed("scale_outside", 64, 0, 1, 0);
    drain("scale");
    stream_region("scale_stream", 60, 0, 0, 2, -1);
  endtask

  task automatic test_shade();
    send_cfg(0, 0, 0, 0, 3, 1); commit();
    run_fixed("shade_quarter", 0, 0, 1, 13'h1321);
    run_fixed("shade_transparent", 15, 0, 1, 0);
    drain("shade");
    stream_region("shade_stream", 40, 0, 0, 0, -1);
  endtask

  task automatic test_double_buffer();
    send_cfg(0, 0, 0, 2, 1, 1);
    n_tot++; if (cfg_ready !== 1'b0) $display("FAIL db_ready_after_a: got %b expected 0", cfg_ready); else n_pass++;
    set_bus(200, 10, 1, 3, 2, 1); cfg_valid = 1;
    repeat (3) tick();
    n_tot++; if (cfg_ready !== 1'b0) $display("FAIL db_b_stall: got %b expected 0", cfg_ready); else n_pass++;
    frame_start = 1;
    n_tot++; if (cfg_ready !== 1'b0) $display("FAIL db_ready_at_commit: got %b expected 0", cfg_ready); else n_pass++;
    model_commit(); tick(); frame_start = 0;
    n_tot++; if (cfg_ready !== 1'b1) $display("FAIL db_ready_after_commit: got %b expected 1", cfg_ready); else n_pass++;
    model_accept(); tick(); cfg_valid = 0;
    n_tot++; if (cfg_ready !== 1'b0) $display("FAIL db_b_pending: got %b expected 0", cfg_ready); else n_pass++;
    stream_region("db_a_active", 30, 0, 0, 0, -1);
    commit();
    stream_region("db_b_active", 30, 200, 10, 1, -1);
    set_bus(300, 100, 0, 1, 0, 1); cfg_valid = 1; frame_start = 1;
    model_accept(); tick(); cfg_valid = 0; frame_start = 0;
    n_tot++; if (cfg_ready !== 1'b0) $display("FAIL db_accept_on_frame: got %b expected 0", cfg_ready); else n_pass++;
    stream_region("db_b_still_active", 30, 200, 10, 1, -1);
    commit();
    stream_region("db_c_active", 30, 300, 100, 0, -1);
    commit();
    stream_region("db_idle_commit", 30, 300, 100, 0, -1);
  endtask

  task automatic test_blank_and_edge();
    send_cfg(100, 50, 0, 1, 0, 1); commit();
    run_fixed("blank_low", 100, 50, 0, 0);
    drain("blank");
    send_cfg(630, 0, 0, 1, 0, 1); commit();
    run_fixed("edge_last_col", 639, 0, 1, 13'h1246);
    run_fixed("edge_no_wrap", 0, 0, 1, 0);
    for (int x = 620; x < 640; x++) run_fixed("edge_row", x, 1, 1, -1);
    for (int x = 0; x < 12; x++) run_fixed("edge_wrap_row", x, 1, 1, -1);
    drain("edge");
  endtask

  task automatic test_random_midline();
    int x0, y0, sc, nx0, ny0, nsc;
    for (int r = 0; r < 4; r++) begin
      x0 = $urandom_range(620); y0 = $urandom_range(460); sc = $urandom_range(3);
      send_cfg(x0, y0, sc, $urandom_range(3), $urandom_range(3), ($urandom_range(7) != 0));
      commit();
      nx0 = $urandom_range(620); ny0 = $urandom_range(460); nsc = $urandom_range(3);
      send_cfg(nx0, ny0, nsc, $urandom_range(3), $urandom_range(3), 1);
      stream_region("rand_old", 80, x0, y0, sc, 40);
      stream_region("rand_new", 80, nx0, ny0, nsc, -1);
    end
  endtask

  task automatic test_reset_midstream();
    send_cfg(100, 50, 0, 1, 0, 1); commit();
    for (int x = 100; x < 106; x++) run_fixed("rst_pre", x, 50, 1, -1);
    DrawX = 100; DrawY = 50; blank = 1; reset = 1; tick();
    n_tot++; if ({hit, red, green, blue} !== 13'd0) $display("FAIL rst_force: got %h expected 0", {hit, red, green, blue}); else n_pass++;
    tick();
    n_tot++; if ({hit, red, green, blue} !== 13'd0) $display("FAIL rst_hold: got %h expected 0", {hit, red, green, blue}); else n_pass++;
    reset = 0; model_reset();
    for (int i = 0; i < 4; i++) run_fixed("rst_no_stale", 100, 50, 1, 0);
    drain("rst_no_stale");
    send_cfg(100, 50, 0, 1, 0, 1); commit();
    run_fixed("rst_latency_idle", 100, 50, 0, 0);
    run_fixed("rst_latency_idle", 100, 50, 0, 0);
    run_fixed("rst_latency_hit", 100, 50, 1, 13'h1F84);
    run_fixed("rst_latency_after", 100, 50, 0, 0);
    drain("rst_latency");
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0; n_pass = 0; n_tot = 0;
    reset = 1; blank = 0; frame_start = 0; cfg_valid = 0; DrawX = 0; DrawY = 0;
    set_bus(0, 0, 0, 0, 0, 0);
    model_reset();
    tick();
    test_reset();
    test_basic();
    test_scale();
    test_shade();
    test_double_buffer();
    test_blank_and_edge();
    test_random_midline();
    test_reset_midstream();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule

// File: doc/texture_sampler.md
TEXTURE_SAMPLER -- requirements
Module: texture_sampler

Interface
REQ-001 Parameter TEX_W_LOG2, default 4, texture width = 2**TEX_W_LOG2 texels.
REQ-002 Parameter TEX_H_LOG2, default 4, texture height = 2**TEX_H_LOG2 texels.
REQ-003 Parameter NUM_TEX, default 4, number of textures in ROM (power of two, >=1).
REQ-004 Parameter IDX_W, default 8, palette index width.
REQ-005 vga_clk  input  1  sole clock; all state on posedge.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 DrawX, DrawY  input  10 each  current pixel coordinate.
REQ-008 blank  input  1  high = active video (pixel drawable).
REQ-009 frame_start  input  1  one-cycle pulse at start of vertical blanking; commit point for config.
REQ-010 cfg_valid / cfg_ready  input / output  1 each  config handshake; transfer when both high on a posedge.
REQ-011 cfg_x0, cfg_y0  input  10 each  sprite top-left screen position.
REQ-012 cfg_scale  input  2  texel size = 2**cfg_scale pixels per side.
REQ-013 cfg_tex_id  input  clog2(NUM_TEX), min 1  texture select.
REQ-014 cfg_shade  input  2  brightness: 0=4/4, 1=3/4, 2=2/4, 3=1/4.
REQ-015 cfg_enable  input  1  sprite drawn when set.
REQ-016 red, green, blue  output  4 each  registered pixel colour.
REQ-017 hit  output  1  registered; high when an opaque sprite texel is output this pixel.

Function
REQ-018 Config path shall be double-buffered: a pending (shadow) set and an active set.
REQ-019 cfg_ready shall equal NOT pending_full; a handshake loads the shadow set and sets pending_full.
REQ-020 On frame_start with pending_full set, active <= shadow, pending_full cleared; cfg_ready is therefore low in that cycle and no transfer occurs.
REQ-021 A config accepted in a cycle with frame_start high and pending_full clear shall become pending, committed at the next frame_start, not the current one.
REQ-022 frame_start with pending_full clear shall leave the active set unchanged.
REQ-023 Pipeline shall have three register stages; red/green/blue/hit reflect inputs (DrawX, DrawY, blank) sampled exactly 3 cycles earlier, throughput one pixel per cycle.
REQ-024 Stage 1: dx = DrawX - x0, dy = DrawY - y0, computed 11-bit signed; in_rect = dx>=0, dy>=0, dx < (2**TEX_W_LOG2 << scale), dy < (2**TEX_H_LOG2 << scale); register in_rect AND enable AND blank, plus ROM address.
REQ-025 Texel u = dx >> scale, v = dy >> scale; ROM address = tex_id*W*H + v*W + u, width clog2(NUM_TEX*W*H).
REQ-026 Stage 2: synchronous ROM read on posedge vga_clk (no negedge clocking), qualifier delayed alongside.
REQ-027 Stage 3: palette index 0 is transparent; qualified AND index!=0 -> hit<=1, each channel <= (c*(4-shade))>>2 truncated to 4 bits; otherwise hit<=0, red=green=blue<=0.
REQ-028 Shade and tex_id used shall be the active values at stage-1 sampling time, carried down the pipeline; a commit mid-line affects only later pixels.
REQ-029 Sprite extending past screen edge (x0+width > 639) shall be clipped naturally by DrawX range; no wrap-around of dx.

Reset
REQ-030 On reset: red/green/blue = 0, hit = 0, all pipeline qualifiers = 0, pending_full = 0, cfg_ready = 1 the following cycle.
REQ-031 On reset the active set shall be x0=0, y0=0, scale=0, tex_id=0, shade=0, enable=0; shadow contents don't-care.
REQ-032 Reset asserted mid-frame shall force hit=0 and black output from the next cycle; no stale pipeline data emerges after release.

Structure
REQ-033 Shared package texture_pkg shall hold the cfg struct typedef, shade encoding constants, and the palette lookup function (index -> 12-bit RGB).
REQ-034 One sub-module texture_sampler_rom: synchronous-read ROM, parameters NUM_TEX/TEX_W_LOG2/TEX_H_LOG2/IDX_W, initialised from a memory file.
REQ-035 Palette shall be combinational via the package function within stage 3; no separate palette module.

Verification
REQ-036 Reset, then cfg x0=100,y0=50,scale=0,tex_id=1,shade=0,enable=1, frame_start; pixel (100,50) blank=1 -> 3 cycles later hit=1, RGB = palette(ROM[256]).
REQ-037 scale=2, x0=0,y0=0: pixels (0..3,0) all map to address tex_id*256+0; pixel (64,0) -> hit=0 (dx=64 = 16<<2, outside).
REQ-038 shade=3 on texel with palette RGB F,8,4 -> output 3,2,1; ROM index 0 -> hit=0, RGB 0.
REQ-039 Send cfg A, then cfg B without frame_start -> cfg_ready low after A, B stalls; frame_start -> A active, B accepted next cycle, active only after second frame_start.
REQ-040 blank=0 over an in-rect pixel -> hit=0, RGB 0 three cycles later; x0=630 -> columns 630..639 drawn, no wrap to column 0.
REQ-041 Assert reset during a streaming run of hits -> outputs 0 from next cycle; after release first valid output appears exactly 3 cycles after first sampled pixel.
